// File: rtl/bmg_soft.sv
// bmg_soft: soft-decision branch metric generator; each accepted symbol is swept over
// 2^WD_FSM segments of 2*N_ACS lanes. Define BMG_SOFT_PUNCT_EN for the EraseMask port.
module bmg_soft #(
   parameter int unsigned WD_SOFT = 3,
   parameter int unsigned N_CODE  = 2,
   parameter int unsigned N_ACS   = 8,
   parameter int unsigned WD_FSM  = 5,
   parameter int unsigned WD_DIST = 4,
   parameter logic [N_CODE*(WD_FSM+$clog2(N_ACS)+1)-1:0] POLYS = {9'o753, 9'o561}
) (
   input  logic                       Clock2,
   input  logic                       Reset,
   input  logic                       InValid,
   output logic                       InReady,
   input  logic [N_CODE*WD_SOFT-1:0]  Code,
`ifdef BMG_SOFT_PUNCT_EN
   input  logic [N_CODE-1:0]          EraseMask,
`endif
   output logic [WD_DIST*2*N_ACS-1:0] Distance,
   output logic [WD_FSM-1:0]          OutSegment,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic                       OutLast
);

   localparam int unsigned LW = $clog2(N_ACS) + 1;
   localparam int unsigned K  = WD_FSM + LW;
   localparam logic [WD_SOFT-1:0] SOFT_MAX = '1;

   if (WD_DIST < WD_SOFT + $clog2(N_CODE)) begin : g_chk_dist
      $error("bmg_soft: WD_DIST too narrow for WD_SOFT and N_CODE");
   end
   if ((N_ACS & (N_ACS - 1)) != 0) begin : g_chk_acs
      $error("bmg_soft: N_ACS must be a power of 2");
   end

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [WD_FSM-1:0]          r_seg_cnt;
   logic [N_CODE*WD_SOFT-1:0]  r_code;
   logic [N_CODE-1:0]          w_erase;
   logic                       w_advance;
   logic                       w_last_seg;
   logic                       w_load;
   logic                       w_in_xfer;
   logic [WD_DIST*2*N_ACS-1:0] w_dist;
   logic [K-1:0]               w_bid;
   logic [WD_SOFT-1:0]         w_sym;
   logic [WD_DIST-1:0]         w_sum;

`ifdef BMG_SOFT_PUNCT_EN
   logic [N_CODE-1:0] r_mask;

   always_ff @(posedge Clock2 or negedge Reset) begin
      if (!Reset) begin
         r_mask <= '0;
      end else if (w_in_xfer) begin
         r_mask <= EraseMask;
      end
   end

   assign w_erase = r_mask;
`else
   assign w_erase = '0;
`endif

   assign w_advance  = !OutValid || OutReady;
   assign w_last_seg = (r_seg_cnt == '1);
   assign w_load     = (r_state == SWEEP) && w_advance;
   // Accepting during the final load lets the next symbol follow without a bubble.
   assign InReady    = (r_state == IDLE) || (w_load && w_last_seg);
   assign w_in_xfer  = InValid && InReady;

   always_ff @(posedge Clock2 or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_in_xfer) w_state_nxt = SWEEP;
         SWEEP:   if (w_load && w_last_seg && !w_in_xfer) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_dist = '0;
      w_bid  = '0;
      w_sym  = '0;
      w_sum  = '0;
      for (int unsigned k = 0; k < 2*N_ACS; k++) begin
         w_sum = '0;
         w_bid = {r_seg_cnt, LW'(k)};
         for (int unsigned j = 0; j < N_CODE; j++) begin
            w_sym = r_code[j*WD_SOFT +: WD_SOFT];
            if (!w_erase[j]) begin
               if (^(w_bid & POLYS[j*K +: K])) begin
                  w_sum = w_sum + WD_DIST'(SOFT_MAX - w_sym);
               end else begin
                  w_sum = w_sum + WD_DIST'(w_sym);
               end
            end
         end
         w_dist[k*WD_DIST +: WD_DIST] = w_sum;
      end
   end

   always_ff @(posedge Clock2 or negedge Reset) begin
      if (!Reset) begin
         r_seg_cnt  <= '0;
         r_code     <= '0;
         Distance   <= '0;
         OutSegment <= '0;
         OutValid   <= 1'b0;
         OutLast    <= 1'b0;
      end else begin
         if (w_load) begin
            Distance   <= w_dist;
            OutSegment <= r_seg_cnt;
            OutLast    <= w_last_seg;
            OutValid   <= 1'b1;
            r_seg_cnt  <= r_seg_cnt + 1'b1;
         end else if (OutValid && OutReady) begin
            OutValid <= 1'b0;
         end
         // A new symbol overrides the increment issued by the same final load.
         if (w_in_xfer) begin
            r_code    <= Code;
            r_seg_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_bmg_soft.sv
// tb_bmg_soft: self-checking bench for bmg_soft; a negedge monitor scores every output beat
// against an arithmetic model of the branch metrics, scenario tasks check timing and control.
module tb_bmg_soft;

   localparam int WS   = 3;
   localparam int NC   = 2;
   localparam int NA   = 8;
   localparam int WF   = 5;
   localparam int WD   = 4;
   localparam int NSEG = 32;

   typedef logic [NC*WS-1:0]   code_t;
   typedef logic [WD*2*NA-1:0] dist_t;

   logic         Clock2   = 1'b0;
   logic         Reset    = 1'b1;
   logic         InValid  = 1'b0;
   logic         OutReady = 1'b0;
   code_t        Code     = '0;
   logic         InReady;
   logic         OutValid;
   logic         OutLast;
   dist_t        Distance;
   logic [WF-1:0] OutSegment;
`ifdef BMG_SOFT_PUNCT_EN
   logic [NC-1:0] EraseMask = '0;
`endif

   int n_tests  = 0;
   int n_fail   = 0;
   int beats    = 0;
   int last_cnt = 0;
   int n_acc    = 0;
   int exp_seg  = 0;
   code_t         sym_q[$];
   logic [NC-1:0] msk_q[$];
   dist_t         ev;
   logic          el;

   always #5 Clock2 = ~Clock2;

   bmg_soft dut (
      .Clock2     (Clock2),
      .Reset      (Reset),
      .InValid    (InValid),
      .InReady    (InReady),
      .Code       (Code),
`ifdef BMG_SOFT_PUNCT_EN
      .EraseMask  (EraseMask),
`endif
      .Distance   (Distance),
      .OutSegment (OutSegment),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .OutLast    (OutLast)
   );

   // Branch metric from first principles: branch id = seg*16 + lane, parity by popcount.
   function automatic int ref_metric(int seg, int k, code_t code, logic [NC-1:0] er);
      int id, sum, pol, sym, ones, c;
      id  = seg * (2*NA) + k;
      sum = 0;
      c   = int'(code);
      for (int j = 0; j < NC; j++) begin
         pol  = (j == 0) ? 'o561 : 'o753;
         sym  = (c >> (WS*j)) & ((1 << WS) - 1);
         ones = 0;
         for (int b = 0; b < 9; b++) if (((id & pol) >> b) & 1) ones++;
         if (!er[j]) sum += (ones % 2 == 1) ? ((1 << WS) - 1 - sym) : sym;
      end
      return sum;
   endfunction

   function automatic dist_t exp_dist(int seg, code_t code, logic [NC-1:0] er);
      dist_t v;
      v = '0;
      for (int k = 0; k < 2*NA; k++) v[k*WD +: WD] = WD'(ref_metric(seg, k, code, er));
      return v;
   endfunction

   always @(negedge Clock2) begin
      if (Reset !== 1'b1) begin
         sym_q.delete();
         msk_q.delete();
         exp_seg = 0;
      end else begin
         if (InValid && InReady) begin
            sym_q.push_back(Code);
`ifdef BMG_SOFT_PUNCT_EN
            msk_q.push_back(EraseMask);
`else
            msk_q.push_back('0);
`endif
            n_acc++;
         end
         if (OutValid && OutReady) begin
            n_tests++;
            if (sym_q.size() == 0) begin
               n_fail++;
               $display("FAIL beat_spurious: got beat seg=%0d, required no beat", OutSegment);
            end else begin
               ev = exp_dist(exp_seg, sym_q[0], msk_q[0]);
               el = (exp_seg == NSEG-1);
               if (OutSegment !== WF'(exp_seg) || OutLast !== el || Distance !== ev) begin
                  n_fail++;
                  $display("FAIL beat: got seg=%0d last=%b dist=%h, required seg=%0d last=%b dist=%h",
                           OutSegment, OutLast, Distance, exp_seg, el, ev);
               end
               beats++;
               if (el) begin
                  last_cnt++;
                  exp_seg = 0;
                  void'(sym_q.pop_front());
                  void'(msk_q.pop_front());
               end else begin
                  exp_seg++;
               end
            end
         end
      end
   end

   task automatic test_reset();
      #1 Reset = 1'b0;
      repeat (3) @(posedge Clock2);
      #1;
      n_tests++;
      if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b required 0", OutValid); end
      n_tests++;
      if (Distance !== '0) begin n_fail++; $display("FAIL reset_distance: got %h required 0", Distance); end
      n_tests++;
      if (OutSegment !== '0 || OutLast !== 1'b0) begin
         n_fail++; $display("FAIL reset_seg_last: got %0d/%b required 0/0", OutSegment, OutLast);
      end
      Reset = 1'b1;
      @(posedge Clock2); #1;
      n_tests++;
      if (InReady !== 1'b1 || OutValid !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: got inready=%b outvalid=%b required 1/0", InReady, OutValid);
      end
   endtask

   task automatic test_first_symbol();
      int b0, l0, cyc;
      b0 = beats; l0 = last_cnt;
      Code = '0; InValid = 1'b1; OutReady = 1'b1;
      @(posedge Clock2); #1;
      InValid = 1'b0;
      n_tests++;
      if (OutValid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got outvalid=%b required 0", OutValid); end
      @(posedge Clock2); #1;
      n_tests++;
      if (OutValid !== 1'b1 || OutSegment !== '0) begin
         n_fail++; $display("FAIL latency_first: got valid=%b seg=%0d required 1/0", OutValid, OutSegment);
      end
      n_tests++;
      if (Distance[3:0] !== 4'd0 || Distance[7:4] !== 4'd14 || Distance[11:8] !== 4'd7) begin
         n_fail++; $display("FAIL first_lanes: got %0d/%0d/%0d required 0/14/7",
                            Distance[3:0], Distance[7:4], Distance[11:8]);
      end
      cyc = 0;
      while (beats < b0 + NSEG && cyc < 100) begin @(posedge Clock2); #1; cyc++; end
      n_tests++;
      if (beats != b0 + NSEG || last_cnt != l0 + 1 || OutValid !== 1'b0) begin
         n_fail++; $display("FAIL first_sweep: got beats=%0d lasts=%0d valid=%b required %0d/1/0",
                            beats - b0, last_cnt - l0, OutValid, NSEG);
      end
   endtask

   task automatic test_back_to_back();
      int b0, cyc, acc, gaps, acc_seg;
      logic seen, acc_vld;
      code_t c2;
      b0 = beats; cyc = 0; acc = 0; gaps = 0; acc_seg = -1; seen = 1'b0; acc_vld = 1'b0;
      Code = code_t'($urandom); c2 = code_t'($urandom);
      InValid = 1'b1; OutReady = 1'b1;
      while ((acc < 2 || beats < b0 + 2*NSEG) && cyc < 300) begin
         if (InValid && InReady === 1'b1) begin
            acc++;
            if (acc == 2) begin acc_seg = int'(OutSegment); acc_vld = OutValid; end
         end
         @(posedge Clock2); #1; cyc++;
         if (acc == 1) Code = c2;
         else if (acc >= 2) InValid = 1'b0;
         if (OutValid === 1'b1) seen = 1'b1;
         else if (seen && beats < b0 + 2*NSEG) gaps++;
      end
      n_tests++;
      if (beats != b0 + 2*NSEG || gaps != 0) begin
         n_fail++; $display("FAIL b2b_beats: got beats=%0d gaps=%0d required 64/0", beats - b0, gaps);
      end
      n_tests++;
      if (acc_vld !== 1'b1 || acc_seg != NSEG-2) begin
         n_fail++; $display("FAIL b2b_accept: got shown_seg=%0d valid=%b required 30/1 (beat-31 load)",
                            acc_seg, acc_vld);
      end
      n_tests++;
      if (OutValid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got outvalid=%b required 0", OutValid); end
   endtask

   task automatic test_stall();
      int b0, cyc;
      dist_t d;
      b0 = beats; cyc = 0;
      Code = code_t'($urandom); InValid = 1'b1; OutReady = 1'b1;
      @(posedge Clock2); #1;
      InValid = 1'b0;
      while (!(OutValid === 1'b1 && OutSegment == 5'd3) && cyc < 50) begin @(posedge Clock2); #1; cyc++; end
      n_tests++;
      if (OutSegment !== 5'd3) begin n_fail++; $display("FAIL stall_reach: got seg=%0d required 3", OutSegment); end
      OutReady = 1'b0;
      d = Distance;
      repeat (5) begin
         @(posedge Clock2); #1;
         n_tests++;
         if (OutValid !== 1'b1 || OutSegment !== 5'd3 || Distance !== d) begin
            n_fail++; $display("FAIL stall_hold: got valid=%b seg=%0d dist=%h required 1/3/%h",
                               OutValid, OutSegment, Distance, d);
         end
      end
      OutReady = 1'b1;
      @(posedge Clock2); #1;
      n_tests++;
      if (OutSegment !== 5'd4) begin n_fail++; $display("FAIL stall_resume: got seg=%0d required 4", OutSegment); end
      cyc = 0;
      while (beats < b0 + NSEG && cyc < 100) begin @(posedge Clock2); #1; cyc++; end
      n_tests++;
      if (beats != b0 + NSEG) begin n_fail++; $display("FAIL stall_count: got %0d required 32", beats - b0); end
   endtask

   task automatic test_random();
      int b0, a0, cyc;
      b0 = beats; a0 = n_acc; cyc = 0;
      while ((n_acc - a0 < 6 || beats < b0 + 6*NSEG) && cyc < 4000) begin
         OutReady = ($urandom_range(0, 9) < 7);
         if (n_acc - a0 < 6) begin
            InValid = ($urandom_range(0, 3) != 0);
            Code    = code_t'($urandom);
         end else begin
            InValid = 1'b0;
         end
         @(posedge Clock2); #1; cyc++;
      end
      InValid = 1'b0; OutReady = 1'b1;
      @(posedge Clock2); #1;
      n_tests++;
      if (n_acc - a0 != 6 || beats != b0 + 6*NSEG) begin
         n_fail++; $display("FAIL random_count: got acc=%0d beats=%0d required 6/192", n_acc - a0, beats - b0);
      end
   endtask

   task automatic test_reset_mid();
      int b0, cyc, quiet;
      cyc = 0; quiet = 0;
      Code = code_t'($urandom); InValid = 1'b1; OutReady = 1'b1;
      @(posedge Clock2); #1;
      InValid = 1'b0;
      while (!(OutValid === 1'b1 && OutSegment == 5'd10) && cyc < 50) begin @(posedge Clock2); #1; cyc++; end
      n_tests++;
      if (OutSegment !== 5'd10) begin n_fail++; $display("FAIL rstmid_reach: got seg=%0d required 10", OutSegment); end
      #2 Reset = 1'b0;
      #1;
      n_tests++;
      if (OutValid !== 1'b0 || OutSegment !== '0 || Distance !== '0) begin
         n_fail++; $display("FAIL rstmid_async: got valid=%b seg=%0d dist=%h required 0/0/0",
                            OutValid, OutSegment, Distance);
      end
      @(posedge Clock2); #1;
      @(posedge Clock2); #1;
      Reset = 1'b1;
      repeat (4) begin
         @(posedge Clock2); #1;
         if (OutValid !== 1'b0) quiet++;
      end
      n_tests++;
      if (quiet != 0 || InReady !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_quiet: got stray=%0d inready=%b required 0/1", quiet, InReady);
      end
      b0 = beats;
      Code = code_t'($urandom); InValid = 1'b1;
      @(posedge Clock2); #1;
      InValid = 1'b0;
      @(posedge Clock2); #1;
      n_tests++;
      if (OutValid !== 1'b1 || OutSegment !== '0) begin
         n_fail++; $display("FAIL rstmid_restart: got valid=%b seg=%0d required 1/0", OutValid, OutSegment);
      end
      cyc = 0;
      while (beats < b0 + NSEG && cyc < 100) begin @(posedge Clock2); #1; cyc++; end
      n_tests++;
      if (beats != b0 + NSEG) begin n_fail++; $display("FAIL rstmid_count: got %0d required 32", beats - b0); end
   endtask

`ifdef BMG_SOFT_PUNCT_EN
   task automatic test_puncture();
      int b0, cyc;
      b0 = beats; cyc = 0;
      Code = '0; EraseMask = 2'b10; InValid = 1'b1; OutReady = 1'b1;
      @(posedge Clock2); #1;
      InValid = 1'b0; EraseMask = '0;
      @(posedge Clock2); #1;
      n_tests++;
      if (OutSegment !== '0 || Distance[7:4] !== 4'd7 || Distance[11:8] !== 4'd0) begin
         n_fail++; $display("FAIL puncture_lanes: got seg=%0d l1=%0d l2=%0d required 0/7/0",
                            OutSegment, Distance[7:4], Distance[11:8]);
      end
      while (beats < b0 + NSEG && cyc < 100) begin @(posedge Clock2); #1; cyc++; end
      n_tests++;
      if (beats != b0 + NSEG) begin n_fail++; $display("FAIL puncture_count: got %0d required 32", beats - b0); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_symbol();
      test_back_to_back();
      test_stall();
      test_random();
      test_reset_mid();
`ifdef BMG_SOFT_PUNCT_EN
      test_puncture();
`endif
      repeat (2) @(posedge Clock2);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bmg_soft.md
BMG_SOFT -- requirements
Module: bmg_soft

Interface
REQ-001 Parameter WD_SOFT, default 3, soft-symbol width; 0 means strongest '0' and 2^WD_SOFT-1 means strongest '1'.
REQ-002 Parameter N_CODE, default 2, code symbols per branch (code rate 1/N_CODE).
REQ-003 Parameter N_ACS, default 8, ACS units served per segment; SHALL be a power of 2.
REQ-004 Parameter WD_FSM, default 5, segment counter width; 2^WD_FSM segments per symbol.
REQ-005 Parameter WD_DIST, default 4, metric width; SHALL be at least WD_SOFT+clog2(N_CODE) (elaboration error otherwise).
REQ-006 Parameter POLYS, default {9'o753, 9'o561}, N_CODE generator polynomials of K=WD_FSM+clog2(N_ACS)+1 bits each; poly j at [j*K +: K].
REQ-007 Clock2  input  1  clock, rising edge.
REQ-008 Reset  input  1  asynchronous, active-low reset.
REQ-009 InValid  input  1  Code (and EraseMask) valid.
REQ-010 InReady  output  1  block accepts a symbol this cycle.
REQ-011 Code  input  N_CODE*WD_SOFT  received soft symbols; symbol j at [j*WD_SOFT +: WD_SOFT].
REQ-012 EraseMask  input  N_CODE  per-symbol puncture flag (present only with BMG_SOFT_PUNCT_EN).
REQ-013 Distance  output  WD_DIST*2*N_ACS  branch metrics; lane k=2*a+b at [k*WD_DIST +: WD_DIST], a = ACS index, b = branch bit.
REQ-014 OutSegment  output  WD_FSM  segment that Distance belongs to.
REQ-015 OutValid  output  1  Distance/OutSegment/OutLast valid.
REQ-016 OutReady  input  1  downstream consumes output this cycle.
REQ-017 OutLast  output  1  marks final segment (2^WD_FSM-1) of a symbol.

Function
REQ-018 Transfer on input SHALL occur when InValid&&InReady; on output when OutValid&&OutReady.
REQ-019 FSM states: IDLE and SWEEP; IDLE -> SWEEP on input transfer; SWEEP -> IDLE after the last segment is issued with no concurrent input transfer.
REQ-020 On input transfer the block SHALL register Code (and EraseMask) and set the segment counter SegCnt to 0.
REQ-021 In SWEEP, when the output register is empty or OutReady=1 (advance), the block SHALL load Distance for SegCnt, set OutSegment=SegCnt, OutLast=(SegCnt==2^WD_FSM-1), OutValid=1, and then increment SegCnt.
REQ-022 BranchID for lane k SHALL be {SegCnt, a, b} (K bits, SegCnt in MSBs); expected bit e_j = XOR-reduce(BranchID & poly j).
REQ-023 Lane metric SHALL be the sum over j of (e_j ? (2^WD_SOFT-1)-Code_j : Code_j), zero-extended to WD_DIST; no overflow is possible by REQ-005.
REQ-024 InReady SHALL be 1 in IDLE, and 1 in SWEEP only during the advance cycle that issues the last segment; a transfer then restarts SWEEP at SegCnt 0, giving a sustained throughput of one symbol per 2^WD_FSM cycles.
REQ-025 Latency: first output loaded on the edge after the input-transfer edge (OutValid high one cycle after acceptance).
REQ-026 While OutValid=1 and OutReady=0, Distance, OutSegment, OutLast and SegCnt SHALL hold stable.
REQ-027 In IDLE with an output transfer and no new load, OutValid SHALL drop to 0.
REQ-028 The registered Code SHALL NOT change during SWEEP except via REQ-024.

Reset
REQ-029 Reset=0 SHALL asynchronously force state IDLE, SegCnt=0, Code register=0, Distance=0, OutSegment=0, OutValid=0, OutLast=0, InReady=1 (after release); reset mid-sweep SHALL discard the symbol with no further outputs.

Configuration
REQ-030 Macro BMG_SOFT_PUNCT_EN defined: EraseMask port exists and is registered with Code; symbol j with mask bit 1 contributes 0 to every lane metric.
REQ-031 Macro BMG_SOFT_PUNCT_EN undefined: no EraseMask port; all symbols always contribute.

Verification (default parameters, 32 segments)
REQ-032 Reset release, Code={3'd0,3'd0} accepted, OutReady=1 -> first beat OutSegment=0, lane0=0, lane1=14, lane2=7; OutLast only on beat 31.
REQ-033 Two back-to-back symbols, InValid held high -> exactly 64 consecutive OutValid beats, second symbol accepted in the beat-31 advance cycle, segments 0..31 twice.
REQ-034 OutReady=0 for 5 cycles at segment 3 -> Distance/OutSegment=3 frozen, resumes with segment 4, no beat lost or duplicated.
REQ-035 Reset asserted at segment 10 -> OutValid=0 immediately (asynchronously), InReady=1 after release, next symbol starts at segment 0.
REQ-036 BMG_SOFT_PUNCT_EN defined, Code={3'd0,3'd0}, EraseMask=2'b10 -> segment 0 lane1=7, lane2=0; undefined build -> compiles without EraseMask, lane1=14.
